// File: rtl/kb_event_queue.sv
// kb_event_queue: Set-2 scan-code decoder with shift/caps tracking and a key-event FIFO.
// Define KB_EVQ_BREAK_EVENTS_EN to also queue non-modifier breaks with ev_break_o=1.
module kb_event_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            scan_code_i,
  input  logic                  scan_code_ready_i,
  output logic [7:0]            ev_code_o,
  output logic                  ev_ext_o,
  output logic                  ev_shift_o,
  output logic                  ev_caps_o,
  output logic                  ev_break_o,
  output logic                  ev_valid_o,
  input  logic                  ev_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic                  caps_lock_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef KB_EVQ_BREAK_EVENTS_EN
  localparam logic BRK_EN = 1'b1;
`else
  localparam logic BRK_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t state_q, state_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d, held_q, held_d, caps_q, caps_d, ovf_q, ovf_d;
  logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic [11:0] mem [DEPTH];
  logic [11:0] head;
  logic ignored, make, brk, ext, is_shift, is_caps, push, pop, full, accept;
  always_comb begin
    ignored = scan_code_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    state_d = state_q;
    make = 1'b0;
    brk = 1'b0;
    ext = (state_q == EXT) || (state_q == EXT_BRK);
    if (scan_code_ready_i)
      case (state_q)
        IDLE:
          if (scan_code_i == 8'hE0) state_d = EXT;
          else if (scan_code_i == 8'hF0) state_d = BRK;
          else make = !ignored;
        EXT:
          if (scan_code_i == 8'hF0) state_d = EXT_BRK;
          else if (scan_code_i != 8'hE0) begin
            make = 1'b1;
            state_d = IDLE;
          end
        BRK, EXT_BRK: begin
          brk = 1'b1;
          state_d = IDLE;
        end
      endcase
  end
  // Extended 12/59 are fake shifts: swallowed but never change modifier state.
  always_comb begin
    is_shift = (scan_code_i == 8'h12) || (scan_code_i == 8'h59);
    is_caps = (scan_code_i == 8'h58) && !ext;
    lshift_d = ((make || brk) && !ext && scan_code_i == 8'h12) ? make : lshift_q;
    rshift_d = ((make || brk) && !ext && scan_code_i == 8'h59) ? make : rshift_q;
    caps_d = (is_caps && make) ? caps_q ^ !held_q : caps_q;
    held_d = (is_caps && make) ? 1'b1 : (is_caps && brk) ? 1'b0 : held_q;
    push = (make || (BRK_EN && brk)) && !is_shift && !is_caps;
    full = cnt_q[DEPTH_LOG2];
    pop = ev_valid_o && ev_ready_i;
    accept = push && (!full || pop);
    rd_d = rd_q + DEPTH_LOG2'(pop);
    wr_d = wr_q + DEPTH_LOG2'(accept);
    cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(accept) - (DEPTH_LOG2 + 1)'(pop);
    ovf_d = ovf_q || (push && full && !pop);
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      held_q <= 1'b0;
      caps_q <= 1'b0;
      ovf_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      held_q <= held_d;
      caps_q <= caps_d;
      ovf_q <= ovf_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk_i)
    if (accept) mem[wr_q] <= {brk, ext, lshift_q | rshift_q, caps_q, scan_code_i};
  assign ev_valid_o = cnt_q != '0;
  assign head = ev_valid_o ? mem[rd_q] : 12'h0;
  assign ev_code_o = head[7:0];
  assign ev_caps_o = head[8];
  assign ev_shift_o = head[9];
  assign ev_ext_o = head[10];
  assign ev_break_o = BRK_EN && head[11];
  assign count_o = cnt_q;
  assign overflow_o = ovf_q;
  assign caps_lock_o = caps_q;
endmodule

// File: tb/tb_kb_event_queue.sv
// tb_kb_event_queue: randomized + directed bench with a queue-based reference model and scoreboard monitor.
module tb_kb_event_queue;
`ifdef KB_EVQ_BREAK_EVENTS_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1, sr = 1'b0, rdy = 1'b0;
  logic [7:0] sc = 8'h0;
  logic [7:0] ev_code;
  logic ev_ext, ev_shift, ev_caps, ev_break, ev_valid, overflow, caps_lock;
  logic [3:0] count;
  int checks = 0, errors = 0;
  kb_event_queue #(.DEPTH_LOG2(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scan_code_i(sc), .scan_code_ready_i(sr),
    .ev_code_o(ev_code), .ev_ext_o(ev_ext), .ev_shift_o(ev_shift), .ev_caps_o(ev_caps),
    .ev_break_o(ev_break), .ev_valid_o(ev_valid), .ev_ready_i(rdy), .count_o(count),
    .overflow_o(overflow), .caps_lock_o(caps_lock)
  );
  // Model: expected events {brk,ext,shift,caps,code}, prefix flags and key state.
  logic [11:0] q[$];
  bit p_ext, p_brk, m_l, m_r, m_held, m_caps, m_ovf;
  function automatic void key(bit b, bit e, logic [7:0] c);
    if (c == 8'h12 || c == 8'h59) begin
      if (!e && c == 8'h12) m_l = !b;
      if (!e && c == 8'h59) m_r = !b;
    end else if (c == 8'h58 && !e) begin
      if (!b && !m_held) m_caps = !m_caps;
      m_held = !b;
    end else if (!b || BRK_EN) begin
      if (q.size() < DEPTH) q.push_back({b, e, m_l | m_r, m_caps, c});
      else m_ovf = 1'b1;
    end
  endfunction
  function automatic void byte_in(logic [7:0] c);
    if (!p_brk && c == 8'hE0) p_ext = 1'b1;
    else if (!p_brk && c == 8'hF0) p_brk = 1'b1;
    else if (!p_ext && !p_brk && c inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) ;
    else begin
      key(p_brk, p_ext, c);
      p_ext = 1'b0;
      p_brk = 1'b0;
    end
  endfunction
  always @(posedge clk)
    if (!rst_n) begin
      q.delete();
      {p_ext, p_brk, m_l, m_r, m_held, m_caps, m_ovf} = '0;
    end else begin
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (sr) byte_in(sc);
    end
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    e = q.size() > 0 ? q[0] : 12'h0;
    chk("valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("code", 32'(ev_code), 32'(e[7:0]));
    chk("caps_snap", 32'(ev_caps), 32'(e[8]));
    chk("shift", 32'(ev_shift), 32'(e[9]));
    chk("ext", 32'(ev_ext), 32'(e[10]));
    chk("break", 32'(ev_break), 32'(e[11]));
    chk("count", 32'(count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("caps_lock", 32'(caps_lock), 32'(m_caps));
  end
  task automatic send(logic [7:0] b);
    @(negedge clk);
    sc = b;
    sr = 1'b1;
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      sr = 1'b0;
    end
  endtask
  task automatic drain(int n);
    idle(1);
    rdy = 1'b1;
    idle(n);
    rdy = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    sr = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask
  logic [7:0] pool [12] = '{8'h12, 8'h59, 8'h58, 8'h1C, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'h00, 8'h32, 8'h15, 8'hFA};
  initial begin
    #2 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send(8'h1C); idle(2); drain(1); idle(1);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C); idle(2); drain(3);
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h58); idle(2);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(2); drain(3);
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    idle(2); drain(9);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(8'h20 + 8'(i));
      if (i == 8) rdy = 1'b1;
    end
    idle(1); rdy = 1'b0; drain(9);
    send(8'hE0);
    do_reset();
    send(8'h1C); idle(2); drain(2);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sr = 1'($urandom_range(0, 1));
      sc = $urandom_range(0, 4) == 0 ? 8'($urandom) : pool[$urandom_range(0, 11)];
      rdy = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 599) == 0) do_reset();
    end
    idle(2); drain(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kb_event_queue.md
# kb_event_queue

Downstream consumer of the PS/2 `keyboard` receiver: takes its one-cycle `scan_code`/`scan_code_ready` strobes and decodes Set-2 prefixes (E0 extended, F0 break). It tracks shift and caps-lock state and queues key-make events in a small FIFO. The editor core pops these events through a valid/ready handshake, feeding `translate_to_ASCII` and the text buffer without losing keystrokes while it is busy.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth = 2^DEPTH_LOG2 events.
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  asynchronous, active-low reset (KEY[0]).
- `scan_code`  in  8  byte from `keyboard`; valid only while `scan_code_ready`=1.
- `scan_code_ready`  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- `ev_code`  out  8  head-event scan code (0 when `ev_valid`=0).
- `ev_ext`  out  1  head event was E0-prefixed.
- `ev_shift`  out  1  either shift was held when the head event was captured.
- `ev_caps`  out  1  caps-lock state when the head event was captured.
- `ev_break`  out  1  head event is a release (see Configuration).
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts head; a pop occurs when `ev_valid`&`ev_ready`.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `overflow`  out  1  sticky: an event was dropped.
- `caps_lock`  out  1  live caps-lock state (for LED).

## Operation
- Decoder FSM advances only on `scan_code_ready`. States: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: E0→EXT; F0→BRK. Bytes 00, AA, EE, FA, FE, FF are ignored. Any other byte is a make; return to IDLE.
  - EXT: F0→EXT_BRK; E0→stay in EXT. Any other byte is an extended make; go to IDLE.
  - BRK: the byte is a break; go to IDLE.
  - EXT_BRK: the byte is an extended break; go to IDLE.
- Modifiers are never queued:
  - Make 12 sets `lshift`; make 59 sets `rshift`.
  - Break 12 clears `lshift`; break 59 clears `rshift`.
  - Make 58 toggles `caps_lock` only when `caps_held`=0, then sets `caps_held`. Break 58 clears `caps_held`. Typematic repeats therefore do not re-toggle.
  - Extended make or break of 12 or 59 (fake shifts) is ignored.
- Every other make is pushed as {break=0, ext, shift=lshift|rshift, caps=caps_lock, code}. Shift and caps are the values *before* this byte's update. Typematic repeats are queued.
- FIFO holds 12-bit entries, with `rd_ptr`/`wr_ptr` of DEPTH_LOG2 bits that wrap naturally.
- Push while `count`<2^DEPTH_LOG2 is accepted.
- Push while full is accepted only if a pop occurs the same cycle; `count` then stays at full. Otherwise the event is dropped and `overflow` is set.
- Simultaneous push and pop when empty is impossible (`ev_valid`=0), so the push alone takes effect.
- `overflow` clears only on reset.
- Reset (any time, including mid-prefix): FSM→IDLE; shift, caps_held, caps_lock, pointers, count and overflow all → 0. Queued events are discarded.

## Timing
- Reset values: `ev_valid`=0, `count`=0, `overflow`=0, `caps_lock`=0, `ev_code`/`ev_ext`/`ev_shift`/`ev_caps`/`ev_break`=0.
- Latency: a strobe in cycle N that produces an event updates the FIFO at the closing edge of N. `ev_valid` is 1 in N+1 (if previously empty); `count` updates in N+1.
- `caps_lock` and modifier state update at the edge closing the strobe cycle.
- Head outputs are a combinational read of `mem[rd_ptr]`, masked by `ev_valid`. After a pop at edge E, the next entry is presented in the cycle after E.
- `ev_ready` may be held high permanently; throughput is one pop per cycle.

## Configuration
- `KB_EVQ_BREAK_EVENTS_EN` defined: non-modifier breaks (from BRK and EXT_BRK) are also pushed with `ev_break`=1, using the same shift/caps snapshot rules.
- Not defined: breaks are never queued, and `ev_break` is constant 0.
- Modifier handling is identical in both builds.

## Test plan
- Reset, then strobe 1C → one cycle later `ev_valid`=1, `ev_code`=1C, ext/shift/caps/break=0, `count`=1. Pulse `ev_ready` → `ev_valid`=0.
- Strobe 12, 1C, F0 12, 1C → two events: 1C with shift=1, then 1C with shift=0; `count`=2.
- Strobe 58, 58 (repeat), F0 58, 58 → `caps_lock` goes 1, stays 1, then returns to 0; no events queued.
- Strobe E0 75, then E0 F0 75 → one event: `ev_code`=75, ext=1. With `KB_EVQ_BREAK_EVENTS_EN`, a second event 75, ext=1, break=1.
- DEPTH_LOG2=3, `ev_ready`=0: push 9 makes → `count`=8, `overflow`=1, first 8 codes pop in order. Repeat with a pop on the 9th push cycle → no overflow, `count` stays 8.
- Strobe E0, assert `reset` low mid-sequence, release, strobe 1C → event 1C with ext=0; all outputs are at reset values during reset.
